// File: rtl/dp_ram_stream_reader_if.sv
// Control, RAM-port and output-stream signals of the RAM stream reader.
// The master modport is the reader itself, and the slave modport is its environment.
interface dp_ram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;

  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  start, base_addr, length, ram_dout, m_ready,
    output busy, done, ram_we, ram_din, ram_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, length, ram_dout, m_ready,
    input  busy, done, ram_we, ram_din, ram_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/dp_ram_stream_reader.sv
// Walks a wrapping address range on a synchronous-read RAM port and streams
// the words out as valid/ready with full backpressure.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing RAM addresses
// DRAIN | all addresses issued, waiting for buffer and reads in flight to empty
module dp_ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input logic clk,
  input logic rst,
  dp_ram_stream_reader_if.master bus
);
  // The registered address and the RAM output register form two read stages.
  // Three buffer slots therefore cover both in-flight reads, and one word per cycle is still sustained.
  localparam int DEPTH = 3;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   rem_issue;
  logic [ADDR_WIDTH:0]   rem_beats;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  done_q;
  logic                  a_valid;
  logic                  d_valid;
  logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
  logic [1:0]            rd_ptr;
  logic [1:0]            wr_ptr;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic [2:0]            occupancy;
  logic                  fifo_nonempty;
  logic                  pop;
  logic                  issue;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign fifo_nonempty = (count != 2'd0);
  assign pop           = fifo_nonempty & bus.m_ready;
  assign count_next    = count + {1'b0, d_valid} - {1'b0, pop};
  assign occupancy     = {1'b0, count} + {2'b0, a_valid} + {2'b0, d_valid} - {2'b0, pop};
  assign issue         = (state == READ) && (rem_issue != '0) && (occupancy < 3'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_issue <= '0;
      rem_beats <= '0;
      ram_addr_q <= '0;
      done_q    <= 1'b0;
      a_valid   <= 1'b0;
      d_valid   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      done_q  <= 1'b0;
      a_valid <= 1'b0;
      d_valid <= a_valid;
      count   <= count_next;

      if (d_valid) begin
        fifo_mem[wr_ptr] <= bus.ram_dout;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        rem_beats <= rem_beats - CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            rem_beats <= bus.length;
            if (bus.length == '0) begin
              rem_issue <= '0;
              state     <= DRAIN;
            end else begin
              // The first address goes out with the accepted start.
              ram_addr_q <= bus.base_addr;
              a_valid    <= 1'b1;
              rem_issue  <= bus.length - CNT_ONE;
              state      <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            ram_addr_q <= ram_addr_q + ADDR_ONE;
            a_valid    <= 1'b1;
            rem_issue  <= rem_issue - CNT_ONE;
          end
          if ((rem_issue == '0) || (issue && (rem_issue == CNT_ONE))) state <= DRAIN;
        end
        DRAIN: begin
          if ((count_next == 2'd0) && !a_valid && !d_valid) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.ram_we   = 1'b0;
  assign bus.ram_din  = '0;
  assign bus.ram_addr = ram_addr_q;
  assign bus.m_valid  = fifo_nonempty;
  assign bus.m_data   = fifo_mem[rd_ptr];
  assign bus.m_last   = fifo_nonempty && (rem_beats == CNT_ONE);
endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Bench for dp_ram_stream_reader: a behavioural RAM plus an expected-word queue
// built directly from mem[(base+i) mod depth].
module tb_dp_ram_stream_reader;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DW-1:0] mem [DEPTH];

  dp_ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dp_ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  endtask

  // Cycle 0 is the cycle in which start is high.
  // The task returns at the negedge of the done cycle.
  task automatic run_xfer(input int base, input int len, input bit rand_ready,
                          input bit chk_timing, input bit start_now, input int inj_cyc,
                          input string name);
    logic [DW-1:0] expq [$];
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] prev_addr;
    int cyc, beats, changes, budget, done_cyc;
    bit done_seen, prev_stall;
    for (int i = 0; i < len; i++) expq.push_back(mem[(base + i) % DEPTH]);
    if (!start_now) begin
      @(posedge clk); #1;
    end
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.length    = (AW+1)'(len);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    cyc        = 1;
    beats      = 0;
    changes    = 0;
    done_seen  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_addr  = '0;
    budget     = 4 * len + 20;
    done_cyc   = (len == 0) ? 2 : 3 + len;
    bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      @(negedge clk);
      if (cyc == 1) begin
        if (len > 0) begin
          n_checks++;
          if (bus.ram_addr !== AW'(base)) begin
            n_fail++;
            $display("FAIL %s first ram_addr: got %0d expected %0d", name, bus.ram_addr, base);
          end
        end
        n_checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_din !== '0) begin
          n_fail++;
          $display("FAIL %s ram write port: we=%0b din=%0h expected 0/0", name, bus.ram_we, bus.ram_din);
        end
        prev_addr = bus.ram_addr;
      end else if (bus.ram_addr !== prev_addr) begin
        n_checks++;
        if (bus.ram_addr !== AW'((int'(prev_addr) + 1) % DEPTH)) begin
          n_fail++;
          $display("FAIL %s ram_addr step: got %0d after %0d", name, bus.ram_addr, prev_addr);
        end
        changes++;
        prev_addr = bus.ram_addr;
      end

      if (prev_stall) begin
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
          n_fail++;
          $display("FAIL %s stall hold: valid=%0b data=%0h last=%0b expected 1/%0h/%0b",
                   name, bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
        end
      end
      prev_stall = 1'b0;
      if (bus.m_valid === 1'b1) begin
        if (bus.m_ready) begin
          n_checks++;
          if (beats >= len) begin
            n_fail++;
            $display("FAIL %s extra beat: data=%0h beat %0d of %0d", name, bus.m_data, beats, len);
          end else if (bus.m_data !== expq[beats] || bus.m_last !== (beats == len - 1)) begin
            n_fail++;
            $display("FAIL %s beat %0d: data=%0h last=%0b expected %0h/%0b",
                     name, beats, bus.m_data, bus.m_last, expq[beats], (beats == len - 1));
          end
          if (chk_timing) begin
            n_checks++;
            if (cyc != 3 + beats) begin
              n_fail++;
              $display("FAIL %s beat %0d cycle: got %0d expected %0d", name, beats, cyc, 3 + beats);
            end
          end
          beats++;
        end else begin
          prev_stall = 1'b1;
          prev_data  = bus.m_data;
          prev_last  = bus.m_last;
        end
      end

      if (bus.done === 1'b1) begin
        done_seen = 1'b1;
        n_checks++;
        if (beats != len || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done: beats=%0d busy=%0b expected %0d/0", name, beats, bus.busy, len);
        end
        n_checks++;
        if (changes != ((len == 0) ? 0 : len - 1)) begin
          n_fail++;
          $display("FAIL %s address count: got %0d steps expected %0d", name, changes, (len == 0) ? 0 : len - 1);
        end
        if (len > 0) begin
          n_checks++;
          if (prev_addr !== AW'((base + len - 1) % DEPTH)) begin
            n_fail++;
            $display("FAIL %s last ram_addr: got %0d expected %0d", name, prev_addr, (base + len - 1) % DEPTH);
          end
        end
        if (chk_timing) begin
          n_checks++;
          if (cyc != done_cyc) begin
            n_fail++;
            $display("FAIL %s done cycle: got %0d expected %0d", name, cyc, done_cyc);
          end
        end
        break;
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy: got %0b expected 1 in cycle %0d", name, bus.busy, cyc);
      end
      if (cyc >= budget) begin
        n_fail++;
        $display("FAIL %s timeout: no done after %0d cycles, beats=%0d", name, cyc, beats);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == inj_cyc) begin
        bus.start     = 1'b1;
        bus.base_addr = '0;
        bus.length    = (AW+1)'(3);
      end else begin
        bus.start = 1'b0;
      end
      bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_idle_after(input string name);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after done: done=%0b busy=%0b valid=%0b expected 0/0/0",
               name, bus.done, bus.busy, bus.m_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
        bus.m_data !== '0 || bus.ram_addr !== '0) begin
      n_fail++;
      $display("FAIL reset values: busy=%0b done=%0b valid=%0b last=%0b data=%0h addr=%0d expected all 0",
               bus.busy, bus.done, bus.m_valid, bus.m_last, bus.m_data, bus.ram_addr);
    end
    n_checks++;
    if (bus.ram_we !== 1'b0 || bus.ram_din !== '0) begin
      n_fail++;
      $display("FAIL reset ram port: we=%0b din=%0h expected 0/0", bus.ram_we, bus.ram_din);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle after reset: busy=%0b valid=%0b expected 0/0", bus.busy, bus.m_valid);
    end
  endtask

  task automatic test_basic();
    fill_random();
    for (int i = 0; i < 4; i++) mem[16 + i] = DW'(8'hA0 + i);
    run_xfer(16, 4, 1'b0, 1'b1, 1'b0, 0, "basic");
    check_idle_after("basic");
  endtask

  task automatic test_backpressure();
    fill_random();
    run_xfer(16, 4, 1'b1, 1'b0, 1'b0, 0, "bp_short");
    run_xfer(int'($urandom_range(0, DEPTH - 1)), 40, 1'b1, 1'b0, 1'b0, 0, "bp_long");
    run_xfer(int'($urandom_range(0, DEPTH - 1)), 1, 1'b1, 1'b0, 1'b0, 0, "bp_single");
  endtask

  task automatic test_wrap();
    fill_random();
    mem[1022] = 8'd11;
    mem[1023] = 8'd22;
    mem[0]    = 8'd33;
    run_xfer(1022, 3, 1'b0, 1'b1, 1'b0, 0, "wrap");
    run_xfer(1020, 9, 1'b1, 1'b0, 1'b0, 0, "wrap_bp");
  endtask

  task automatic test_zero_and_ignored();
    fill_random();
    run_xfer(5, 0, 1'b0, 1'b1, 1'b0, 0, "zero_len");
    run_xfer(100, 8, 1'b0, 1'b1, 1'b0, 4, "ignored_start");
    check_idle_after("ignored_start");
  endtask

  task automatic test_reset_mid();
    fill_random();
    @(posedge clk); #1;
    bus.m_ready   = 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(200);
    bus.length    = (AW+1)'(6);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== mem[202]) begin
      n_fail++;
      $display("FAIL reset_mid word2: valid=%0b data=%0h expected 1/%0h", bus.m_valid, bus.m_data, mem[202]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.done !== 1'b0 || bus.ram_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid after: busy=%0b valid=%0b done=%0b addr=%0d expected 0/0/0/0",
               bus.busy, bus.m_valid, bus.done, bus.ram_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid later: done=%0b valid=%0b expected 0/0", bus.done, bus.m_valid);
    end
    run_xfer(300, 5, 1'b1, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_full_depth_back_to_back();
    fill_random();
    run_xfer(0, DEPTH, 1'b0, 1'b1, 1'b0, 0, "full_depth");
    run_xfer(7, 5, 1'b0, 1'b1, 1'b1, 0, "b2b_1");
    run_xfer(int'($urandom_range(0, DEPTH - 1)), 12, 1'b1, 1'b0, 1'b1, 0, "b2b_2");
    check_idle_after("b2b_2");
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.m_ready   = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored();
    test_reset_mid();
    test_full_depth_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
